cmos_downscale_2x: RTL and testbench

//  Halves a camera pixel stream in both axes with a 2x2 box average, e.g. 1920x1080 -> 960x540.

---
 rtl/cmos_downscale_2x_pkg.sv | 44 ++++
 rtl/cmos_downscale_2x_line_buf_sdp.sv | 33 +++
 rtl/cmos_downscale_2x.sv | 138 +++++++++++++
 tb/tb_cmos_downscale_2x.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_downscale_2x_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmos_downscale_2x_pkg
//  Purpose  : Shared widths and arithmetic helpers for the 2x2 box downscaler
//  Revision : 1.0 - initial release
// ============================================================================
package cmos_downscale_2x_pkg;

    localparam int POS_W  = 11;            // x/y position width
    localparam int CH_W   = 8;             // one colour channel
    localparam int NCH    = 3;             // {R,G,B}
    localparam int PIX_W  = NCH * CH_W;    // packed pixel
    localparam int HS_W   = CH_W + 1;      // horizontal pair sum per channel
    localparam int VS_W   = CH_W + 2;      // 2x2 sum per channel
    localparam int HSUM_W = NCH * HS_W;    // packed horizontal pair sum
    localparam int ROUND  = 2;             // half of the divide-by-4

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [HSUM_W-1:0] hsum_t;

    // Per-channel sum of two horizontally adjacent pixels
    function automatic hsum_t hpair(input pix_t a, input pix_t b);
        hsum_t s;
        s = '0;
        for (int c = 0; c < NCH; c++) begin
            s[c*HS_W +: HS_W] = HS_W'(a[c*CH_W +: CH_W]) + HS_W'(b[c*CH_W +: CH_W]);
        end
        return s;
    endfunction

    // Combine two pair sums into a rounded (half-up) 2x2 average
    function automatic pix_t box_avg(input hsum_t top, input hsum_t bot);
        pix_t            p;
        logic [VS_W-1:0] v;
        p = '0;
        for (int c = 0; c < NCH; c++) begin
            v = VS_W'(top[c*HS_W +: HS_W]) + VS_W'(bot[c*HS_W +: HS_W]) + VS_W'(ROUND);
            p[c*CH_W +: CH_W] = v[VS_W-1:2];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_downscale_2x_line_buf_sdp.sv
`default_nettype none
// ============================================================================
//  Module   : line_buf_sdp
//  Purpose  : Simple dual-port RAM holding one line of horizontal pair sums;
//             one write port, one read port with 1-cycle synchronous read
//  Revision : 1.0 - initial release
// ============================================================================
module line_buf_sdp
    import cmos_downscale_2x_pkg::*;
#(
    parameter int DEPTH = 960,
    parameter int WIDTH = HSUM_W,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Unreset storage and read register so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata      <= mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/cmos_downscale_2x.sv
`default_nettype none
// ============================================================================
//  Module   : cmos_downscale_2x
//  Purpose  : Halves a vsync/href/clken pixel stream in both axes using a
//             rounded 2x2 box average; output keeps the same stream format
//  Revision : 1.0 - initial release
// ============================================================================
module cmos_downscale_2x
    import cmos_downscale_2x_pkg::*;
#(
    parameter int IMG_HDISP = 1920,
    parameter int IMG_VDISP = 1080,
    parameter int DW        = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_clken,
    input  logic [DW-1:0]    in_data,
    output logic             out_vsync,
    output logic             out_href,
    output logic             out_clken,
    output logic [DW-1:0]    out_data,
    output logic [POS_W-1:0] out_x_pos,
    output logic [POS_W-1:0] out_y_pos
);

    localparam int               c_depth = IMG_HDISP / 2;
    localparam int               c_aw    = (c_depth > 1) ? $clog2(c_depth) : 1;
    localparam logic [POS_W-1:0] c_hmax  = POS_W'(IMG_HDISP);
    localparam logic [POS_W-1:0] c_vmax  = POS_W'(IMG_VDISP);

    logic             r_vsync_d, r_href_d, r_armed;
    logic [POS_W-1:0] r_col, r_row;
    logic [DW-1:0]    r_pix_even;
    logic             r_href_odd_d;
    logic             r_s1_valid;
    hsum_t            r_s1_hsum;
    logic [POS_W-1:0] r_s1_x, r_s1_y;
    hsum_t            w_rd_hsum;

    // Edge detection; a fresh edge overrides the stored counter in the same cycle
    // so the first pixel of a line (or first line of a frame) gets index 0.
    logic             w_vs_rise, w_href_rise, w_href_fall, w_armed;
    logic [POS_W-1:0] w_col, w_row;
    logic             w_acc, w_take, w_pair, w_href_odd;
    hsum_t            w_hsum;

    assign w_vs_rise   = in_vsync & ~r_vsync_d;
    assign w_href_rise = in_href  & ~r_href_d;
    assign w_href_fall = ~in_href & r_href_d;
    assign w_armed     = r_armed | w_vs_rise;
    assign w_col       = w_href_rise ? '0 : r_col;
    assign w_row       = w_vs_rise   ? '0 : r_row;
    assign w_acc       = in_href & in_clken;
    assign w_take      = w_armed & w_acc & (w_col < c_hmax) & (w_row < c_vmax);
    assign w_pair      = w_take & w_col[0];
    assign w_hsum      = hpair(r_pix_even, in_data);
    assign w_href_odd  = w_armed & in_href & w_row[0];

    // Frame/line counters, arming flag and the even-column pixel latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d  <= 1'b0;
            r_href_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_pix_even <= '0;
        end else begin
            r_vsync_d <= in_vsync;
            r_href_d  <= in_href;
            r_armed   <= w_armed;
            r_col     <= (w_acc && w_col != c_hmax) ? w_col + 1'b1 : w_col;
            r_row     <= (w_href_fall && w_row != c_vmax) ? w_row + 1'b1 : w_row;
            if (w_take && !w_col[0]) r_pix_even <= in_data;
        end
    end

    // Even rows store pair sums; odd rows read them back at the same slot.
    // The two never overlap in one cycle, so no write-to-read bypass exists.
    line_buf_sdp #(
        .DEPTH (c_depth),
        .WIDTH (HSUM_W),
        .AW    (c_aw)
    ) u_line_buf (
        .clk   (clk),
        .we    (w_pair & ~w_row[0]),
        .waddr (w_col[c_aw:1]),
        .wdata (w_hsum),
        .re    (w_pair & w_row[0]),
        .raddr (w_col[c_aw:1]),
        .rdata (w_rd_hsum)
    );

    // Stage 1: hold the current pair sum and position while the RAM read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_hsum    <= '0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_href_odd_d <= 1'b0;
        end else begin
            r_s1_valid   <= w_pair & w_row[0];
            r_href_odd_d <= w_href_odd;
            if (w_pair && w_row[0]) begin
                r_s1_hsum <= w_hsum;
                r_s1_x    <= {1'b0, w_col[POS_W-1:1]};
                r_s1_y    <= {1'b0, w_row[POS_W-1:1]};
            end
        end
    end

    // Stage 2: vertical add, rounding and registered outputs (data held between strobes)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_clken <= 1'b0;
            out_data  <= '0;
            out_x_pos <= '0;
            out_y_pos <= '0;
        end else begin
            out_vsync <= r_vsync_d;
            out_href  <= r_href_odd_d;
            out_clken <= r_s1_valid;
            if (r_s1_valid) begin
                out_data  <= box_avg(w_rd_hsum, r_s1_hsum);
                out_x_pos <= r_s1_x;
                out_y_pos <= r_s1_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmos_downscale_2x.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmos_downscale_2x
//  Purpose  : Scoreboard bench for the 2x2 downscaler on an 8x4 image
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_downscale_2x;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vsync = 1'b0, in_href = 1'b0, in_clken = 1'b0;
    logic [23:0] in_data = '0;
    logic        out_vsync, out_href, out_clken;
    logic [23:0] out_data;
    logic [10:0] out_x_pos, out_y_pos;

    cmos_downscale_2x #(.IMG_HDISP(H), .IMG_VDISP(V), .DW(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vsync  (in_vsync),
        .in_href   (in_href),
        .in_clken  (in_clken),
        .in_data   (in_data),
        .out_vsync (out_vsync),
        .out_href  (out_href),
        .out_clken (out_clken),
        .out_data  (out_data),
        .out_x_pos (out_x_pos),
        .out_y_pos (out_y_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        int          x;
        int          y;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] img [0:7][0:11];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [1:0]  vs_hist  = 2'b00;
    bit          model_armed = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference 2x2 rounded average computed straight from the four pixels
    function automatic logic [23:0] box(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c, input logic [23:0] d);
        logic [23:0] r;
        int          s;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(a[8*ch +: 8]) + int'(b[8*ch +: 8]) + int'(c[8*ch +: 8]) + int'(d[8*ch +: 8]);
            r[8*ch +: 8] = 8'((s + 2) / 4);
        end
        return r;
    endfunction

    // Cycle counter and record of in_vsync as seen at each clock edge
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        vs_hist <= rst_n ? {vs_hist[0], in_vsync} : 2'b00;
    end

    // Output monitor: vsync delay every cycle, scoreboard pop on every strobe
    always @(negedge clk) begin
        if (rst_n) begin
            check("vsync_delay", 64'(out_vsync), 64'(vs_hist[1]));
            if (out_clken) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 64'(out_clken), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_cyc", 64'(cyc), 64'(e.cyc));
                    check("data", 64'(out_data), 64'(e.d));
                    check("pos", 64'({out_x_pos, out_y_pos}), 64'({e.x[10:0], e.y[10:0]}));
                    check("href_at_strobe", 64'(out_href), 64'd1);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        @(posedge clk);
        #1;
        in_vsync    = 1'b1;
        model_armed = 1'b1;
        idle(2);
        in_vsync = 1'b0;
        idle(3);
    endtask

    // One line of len pixels, clken every gap-th cycle; optional reset at pixel rst_at
    task automatic send_line(input int row, input int len, input int gap, input int rst_at);
        int   col;
        int   ph;
        exp_t e;
        col = 0;
        ph  = 0;
        while (col < len) begin
            @(posedge clk);
            #1;
            in_href = 1'b1;
            if (ph == 0) begin
                if (rst_at >= 0 && col == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_outputs", 64'({out_vsync, out_href, out_clken, out_data,
                                               out_x_pos, out_y_pos}), 64'd0);
                    sb.delete();
                    model_armed = 1'b0;
                end
                if (rst_at >= 0 && col == rst_at + 2) rst_n = 1'b1;
                in_clken = 1'b1;
                in_data  = img[row][col];
                if (model_armed && col < H && row < V && (col % 2) == 1 && (row % 2) == 1) begin
                    e.d   = box(img[row-1][col-1], img[row-1][col], img[row][col-1], img[row][col]);
                    e.x   = col / 2;
                    e.y   = row / 2;
                    e.cyc = cyc + 2;
                    sb.push_back(e);
                end
                col++;
            end else begin
                in_clken = 1'b0;
            end
            ph = (ph + 1) % gap;
        end
        @(posedge clk);
        #1;
        in_href  = 1'b0;
        in_clken = 1'b0;
        idle(2);
    endtask

    task automatic send_frame(input int nrows, input int gap, input int len_even, input int len_odd);
        vsync_pulse();
        for (int r = 0; r < nrows; r++) send_line(r, (r % 2 == 0) ? len_even : len_odd, gap, -1);
    endtask

    task automatic fill_flat(input logic [23:0] px);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 12; c++) img[r][c] = px;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 12; c++) img[r][c] = 24'($urandom);
    endtask

    // Known blocks {0,1,2,3}, {0,0,0,1}, {0,0,1,1} in the top-left row pair
    task automatic fill_pattern();
        fill_random();
        img[0][0] = 24'h000000; img[0][1] = 24'h010101; img[1][0] = 24'h020202; img[1][1] = 24'h030303;
        img[0][2] = 24'h000000; img[0][3] = 24'h000000; img[1][2] = 24'h000000; img[1][3] = 24'h010101;
        img[0][4] = 24'h000000; img[0][5] = 24'h000000; img[1][4] = 24'h010101; img[1][5] = 24'h010101;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        fill_random();
        idle(3);
        check("reset_state", 64'({out_vsync, out_href, out_clken, out_data, out_x_pos, out_y_pos}), 64'd0);
        rst_n = 1'b1;
        idle(2);
        // Lines before any vsync must produce nothing
        send_line(0, H, 1, -1);
        send_line(1, H, 1, -1);

        fill_flat(24'h102030);   send_frame(4, 1, H, H);
        fill_pattern();          send_frame(4, 1, 10, 10);
        fill_flat(24'hFFFFFF);   send_frame(4, 1, H, H);
        fill_pattern();          send_frame(4, 3, H, H);
        fill_random();           send_frame(4, 1, H, 5);
        fill_random();           send_frame(6, 1, H, H);

        // Reset in the middle of an odd row drops the rest of the frame
        fill_random();
        vsync_pulse();
        send_line(0, H, 1, -1);
        send_line(1, H, 1, -1);
        send_line(2, H, 1, -1);
        send_line(3, H, 1, 4);
        send_line(0, H, 1, -1);
        send_line(1, H, 1, -1);
        fill_random();           send_frame(4, 1, H, H);

        idle(6);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
